// File: rtl/wishbone_bus_if_pkg.sv
// Shared definitions for the Wishbone classic-cycle CPU port bridge:
// FSM state encodings and the all-zero stall vector.
package wishbone_bus_if_pkg;

  typedef enum logic [1:0] {
    WB_IDLE           = 2'b00,
    WB_BUSY           = 2'b01,
    WB_WAIT_FOR_STALL = 2'b11
  } wb_state_e;

  localparam logic [5:0] StallZero = 6'b000000;

endpackage

// File: rtl/wishbone_bus_if.sv
// Wishbone B4 classic-cycle master for one CPU memory port, with flush abort,
// error termination and read buffering across stalls. Optional bus timeout: WB_TIMEOUT_EN.
module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = DATA_W / 8,
  parameter int STALL_W     = 6,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [DATA_W-1:0]  cpu_data_i,
  input  logic [SEL_W-1:0]   cpu_sel_i,
  output logic [DATA_W-1:0]  cpu_data_o,
  output logic               stallreq_o,
  output logic               bus_err_o,
  input  logic [DATA_W-1:0]  wishbone_data_i,
  input  logic               wishbone_ack_i,
  input  logic               wishbone_err_i,
  output logic [ADDR_W-1:0]  wishbone_addr_o,
  output logic [DATA_W-1:0]  wishbone_data_o,
  output logic               wishbone_we_o,
  output logic [SEL_W-1:0]   wishbone_sel_o,
  output logic               wishbone_stb_o,
  output logic               wishbone_cyc_o
);

  localparam logic [STALL_W-1:0] StallIdle = STALL_W'(StallZero);

  wb_state_e         state;
  logic [DATA_W-1:0] rd_buf;
  logic              start;
  logic              tmo_hit;
  logic              err_eff;
  logic              term;
  logic              stalled;

  assign start   = cpu_ce_i & ~flush_i;
  assign stalled = (stall_i != StallIdle);

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // The last waiting cycle before the budget runs out terminates like an error.
  assign tmo_hit = (state == WB_BUSY) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == WB_IDLE && start) begin
      tmo_cnt <= '0;
    end else if (state == WB_BUSY && !flush_i && !term) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  // Without the timeout a BUSY cycle only ends on ack, err or flush.
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  assign err_eff = wishbone_err_i | tmo_hit;
  assign term    = wishbone_ack_i | err_eff;

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (state)
      WB_IDLE: stallreq_o = start;
      WB_BUSY: begin
        if (!flush_i) begin
          if (term) begin
            if (!err_eff && !wishbone_we_o) cpu_data_o = wishbone_data_i;
          end else begin
            stallreq_o = 1'b1;
          end
        end
      end
      WB_WAIT_FOR_STALL: cpu_data_o = rd_buf;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= WB_IDLE;
      rd_buf          <= '0;
      bus_err_o       <= 1'b0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_we_o   <= 1'b0;
      wishbone_sel_o  <= '0;
      wishbone_stb_o  <= 1'b0;
      wishbone_cyc_o  <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (start) begin
            wishbone_addr_o <= cpu_addr_i;
            wishbone_data_o <= cpu_data_i;
            wishbone_we_o   <= cpu_we_i;
            wishbone_sel_o  <= cpu_sel_i;
            wishbone_stb_o  <= 1'b1;
            wishbone_cyc_o  <= 1'b1;
            state           <= WB_BUSY;
          end
        end
        WB_BUSY: begin
          if (flush_i || term) begin
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
          end
          if (flush_i) begin
            rd_buf <= '0;
            state  <= WB_IDLE;
          end else if (term) begin
            if (err_eff) begin
              rd_buf    <= '0;
              bus_err_o <= 1'b1;
            end else if (!wishbone_we_o) begin
              rd_buf <= wishbone_data_i;
            end
            state <= stalled ? WB_WAIT_FOR_STALL : WB_IDLE;
          end
        end
        WB_WAIT_FOR_STALL: begin
          if (!stalled) state <= WB_IDLE;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed self-checking bench for wishbone_bus_if; inputs change 1 ns after
// each rising edge and outputs are checked 1 ns later.
module tb_wishbone_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wishbone_data_i = '0;
  logic        wishbone_ack_i = 1'b0;
  logic        wishbone_err_i = 1'b0;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;

  int n_cmp = 0;
  int n_bad = 0;

  wishbone_bus_if #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
    .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
    .wishbone_err_i(wishbone_err_i), .wishbone_addr_o(wishbone_addr_o),
    .wishbone_data_o(wishbone_data_o), .wishbone_we_o(wishbone_we_o),
    .wishbone_sel_o(wishbone_sel_o), .wishbone_stb_o(wishbone_stb_o),
    .wishbone_cyc_o(wishbone_cyc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if ({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, bus_err_o, stallreq_o} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 00000", {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, bus_err_o, stallreq_o}); end
    n_cmp++; if ({wishbone_addr_o, wishbone_data_o, wishbone_sel_o, cpu_data_o} !== 100'b0) begin n_bad++; $display("FAIL reset_data: got %h/%h/%h/%h want zeros", wishbone_addr_o, wishbone_data_o, wishbone_sel_o, cpu_data_o); end
    #9 rst = 1'b1;
    $display("reset done");
  endtask

  task automatic test_read_wait();
    int hi = 0;
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0100; cpu_sel_i = 4'hF;
    #1 if (stallreq_o) hi++;
    tick();
    cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
    #1;
    n_cmp++; if ({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o} !== 3'b110) begin n_bad++; $display("FAIL read_ctl: got %b want 110", {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o}); end
    n_cmp++; if (wishbone_addr_o !== 32'h0000_0100) begin n_bad++; $display("FAIL read_addr: got %h want 00000100", wishbone_addr_o); end
    for (int i = 0; i < 3; i++) begin
      if (stallreq_o) hi++;
      n_cmp++; if (cpu_data_o !== 32'h0) begin n_bad++; $display("FAIL read_wait_data: got %h want 0", cpu_data_o); end
      tick();
    end
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'hDEADBEEF;
    #1;
    if (stallreq_o) hi++;
    n_cmp++; if (cpu_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data: got %h want deadbeef", cpu_data_o); end
    n_cmp++; if (hi !== 4) begin n_bad++; $display("FAIL read_stall_cycles: got %0d want 4", hi); end
    tick();
    wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    #1;
    n_cmp++; if ({wishbone_cyc_o, wishbone_stb_o, stallreq_o} !== 3'b000) begin n_bad++; $display("FAIL read_end: got %b want 000", {wishbone_cyc_o, wishbone_stb_o, stallreq_o}); end
    $display("read 00000100 done");
  endtask

  task automatic test_write();
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0200; cpu_data_i = 32'h1234_5678; cpu_sel_i = 4'b0011;
    tick();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if ({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_sel_o} !== 7'b111_0011) begin n_bad++; $display("FAIL write_ctl: got %b want 1110011", {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_sel_o}); end
      n_cmp++; if ({wishbone_addr_o, wishbone_data_o} !== {32'h0000_0200, 32'h1234_5678}) begin n_bad++; $display("FAIL write_bus: got %h/%h want 00000200/12345678", wishbone_addr_o, wishbone_data_o); end
      tick();
    end
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h0BAD_0BAD;
    #1;
    n_cmp++; if ({stallreq_o, cpu_data_o} !== 33'b0) begin n_bad++; $display("FAIL write_ack: got %b/%h want 0/0", stallreq_o, cpu_data_o); end
    tick();
    wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    #1;
    n_cmp++; if ({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_sel_o, wishbone_addr_o, wishbone_data_o} !== 71'b0) begin n_bad++; $display("FAIL write_clear: got %b%b%b %h %h %h want zeros", wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_sel_o, wishbone_addr_o, wishbone_data_o); end
    $display("write 00000200 done");
  endtask

  task automatic test_stall_wait();
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0300; cpu_sel_i = 4'hF;
    tick();
    cpu_ce_i = 1'b0;
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'hCAFE_F00D; stall_i = 6'b000011;
    #1;
    n_cmp++; if (cpu_data_o !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL stall_ack_data: got %h want cafef00d", cpu_data_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      wishbone_ack_i = 1'b0; wishbone_data_i = 32'h1111_1111;
      if (i == 2) stall_i = '0;
      #1;
      n_cmp++; if ({stallreq_o, cpu_data_o} !== {1'b0, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL stall_hold: cycle %0d got %b/%h want 0/cafef00d", i, stallreq_o, cpu_data_o); end
    end
    tick();
    wishbone_data_i = '0;
    #1;
    n_cmp++; if (cpu_data_o !== 32'h0) begin n_bad++; $display("FAIL stall_release: got %h want 0", cpu_data_o); end
    $display("read 00000300 with stall done");
  endtask

  task automatic test_err();
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0500; cpu_sel_i = 4'hF;
    tick();
    cpu_ce_i = 1'b0;
    wishbone_ack_i = 1'b1; wishbone_err_i = 1'b1; wishbone_data_i = 32'hAAAA_5555; stall_i = 6'b000001;
    #1;
    n_cmp++; if ({stallreq_o, cpu_data_o} !== 33'b0) begin n_bad++; $display("FAIL err_comb: got %b/%h want 0/0", stallreq_o, cpu_data_o); end
    tick();
    wishbone_ack_i = 1'b0; wishbone_err_i = 1'b0; wishbone_data_i = '0; stall_i = '0;
    #1;
    n_cmp++; if ({bus_err_o, wishbone_cyc_o} !== 2'b10) begin n_bad++; $display("FAIL err_pulse: got %b want 10", {bus_err_o, wishbone_cyc_o}); end
    n_cmp++; if (cpu_data_o !== 32'h0) begin n_bad++; $display("FAIL err_rdbuf: got %h want 0", cpu_data_o); end
    tick();
    n_cmp++; if (bus_err_o !== 1'b0) begin n_bad++; $display("FAIL err_single: got %b want 0", bus_err_o); end
    $display("read 00000500 error done");
  endtask

  task automatic test_flush();
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0400; cpu_sel_i = 4'hF;
    tick();
    cpu_ce_i = 1'b0;
    #1;
    n_cmp++; if (wishbone_cyc_o !== 1'b1) begin n_bad++; $display("FAIL flush_busy: got %b want 1", wishbone_cyc_o); end
    tick();
    flush_i = 1'b1;
    #1;
    n_cmp++; if ({stallreq_o, cpu_data_o} !== 33'b0) begin n_bad++; $display("FAIL flush_comb: got %b/%h want 0/0", stallreq_o, cpu_data_o); end
    tick();
    flush_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h5555_5555;
    #1;
    n_cmp++; if ({wishbone_cyc_o, wishbone_stb_o, bus_err_o, stallreq_o} !== 4'b0) begin n_bad++; $display("FAIL flush_drop: got %b want 0000", {wishbone_cyc_o, wishbone_stb_o, bus_err_o, stallreq_o}); end
    n_cmp++; if (cpu_data_o !== 32'h0) begin n_bad++; $display("FAIL flush_late_ack: got %h want 0", cpu_data_o); end
    tick();
    wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    #1;
    n_cmp++; if ({bus_err_o, wishbone_cyc_o} !== 2'b00) begin n_bad++; $display("FAIL flush_after: got %b want 00", {bus_err_o, wishbone_cyc_o}); end
    $display("read 00000400 flushed");
  endtask

  task automatic test_timeout();
    int hi = 0;
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0600; cpu_sel_i = 4'hF;
    tick();
    cpu_ce_i = 1'b0;
`ifdef WB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1 if (stallreq_o) hi++;
      tick();
    end
    n_cmp++; if (hi !== 3) begin n_bad++; $display("FAIL timeout_stall_cycles: got %0d want 3", hi); end
    n_cmp++; if ({bus_err_o, wishbone_cyc_o} !== 2'b10) begin n_bad++; $display("FAIL timeout_pulse: got %b want 10", {bus_err_o, wishbone_cyc_o}); end
    $display("read 00000600 timed out");
`else
    for (int i = 0; i < 20; i++) begin
      #1 if (stallreq_o && wishbone_cyc_o) hi++;
      tick();
    end
    n_cmp++; if (hi !== 20) begin n_bad++; $display("FAIL no_timeout_hold: got %0d want 20", hi); end
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h0000_0600;
    tick();
    wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    #1;
    n_cmp++; if ({bus_err_o, wishbone_cyc_o} !== 2'b00) begin n_bad++; $display("FAIL no_timeout_end: got %b want 00", {bus_err_o, wishbone_cyc_o}); end
    $display("read 00000600 long wait done");
`endif
  endtask

  task automatic test_back_to_back();
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0A00; cpu_sel_i = 4'hF;
    tick();
    cpu_addr_i = 32'h0000_0B00;
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h0000_00D1;
    #1;
    n_cmp++; if ({wishbone_addr_o, cpu_data_o} !== {32'h0000_0A00, 32'h0000_00D1}) begin n_bad++; $display("FAIL b2b_first: got %h/%h want 00000a00/000000d1", wishbone_addr_o, cpu_data_o); end
    tick();
    wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    #1;
    n_cmp++; if ({wishbone_cyc_o, stallreq_o} !== 2'b01) begin n_bad++; $display("FAIL b2b_gap: got %b want 01", {wishbone_cyc_o, stallreq_o}); end
    tick();
    cpu_ce_i = 1'b0;
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h0000_00D2;
    #1;
    n_cmp++; if ({wishbone_cyc_o, wishbone_addr_o, cpu_data_o} !== {1'b1, 32'h0000_0B00, 32'h0000_00D2}) begin n_bad++; $display("FAIL b2b_second: got %b/%h/%h want 1/00000b00/000000d2", wishbone_cyc_o, wishbone_addr_o, cpu_data_o); end
    tick();
    wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    #1;
    n_cmp++; if ({wishbone_cyc_o, stallreq_o} !== 2'b00) begin n_bad++; $display("FAIL b2b_end: got %b want 00", {wishbone_cyc_o, stallreq_o}); end
    $display("back-to-back reads done");
  endtask

  task automatic test_reset_mid();
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0700; cpu_data_i = 32'h7777_7777; cpu_sel_i = 4'hF;
    tick();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
    #1;
    n_cmp++; if (wishbone_cyc_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got %b want 1", wishbone_cyc_o); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if ({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, stallreq_o, wishbone_sel_o, wishbone_addr_o, wishbone_data_o} !== 72'b0) begin n_bad++; $display("FAIL rstmid_async: got %b%b%b%b %h %h %h want zeros", wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, stallreq_o, wishbone_sel_o, wishbone_addr_o, wishbone_data_o); end
    #2 rst = 1'b1;
    tick();
    n_cmp++; if ({wishbone_cyc_o, stallreq_o} !== 2'b00) begin n_bad++; $display("FAIL rstmid_after: got %b want 00", {wishbone_cyc_o, stallreq_o}); end
    $display("reset during write done");
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_write();
    test_stall_wait();
    test_err();
    test_flush();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
